// File: rtl/rec_play_pkg.sv
// ============================================================================
// rec_play_pkg : shared types, defaults and bank-select helpers for rec_play_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package rec_play_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DEPTH  = 256;
  localparam int DEF_NBANK  = 6;
  localparam int DEF_NOTE_W = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    REC        = 3'd1,
    PLAY_FETCH = 3'd2,
    PLAY_WAIT  = 3'd3,
    PLAY_HOLD  = 3'd4
  } state_t;

  // True when exactly one bit is set (zero and multi-hot are both rejected).
  function automatic logic onehot_valid(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic int onehot_to_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bank_len_file.sv
// ============================================================================
// bank_len_file : per-bank recorded-note count registers, 1 write / 1 read port
// Rev 1.0
// ============================================================================
`default_nettype none

module bank_len_file #(
  parameter int NBANK = 6,
  parameter int LEN_W = 9,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [LEN_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [LEN_W-1:0] rdata
);

  logic [LEN_W-1:0] len_q [NBANK];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NBANK; i++) len_q[i] <= '0;
    end else if (we && (int'(waddr) < NBANK)) begin
      len_q[waddr] <= wdata;
    end
  end

  // Index codes beyond NBANK read as an empty bank.
  assign rdata = (int'(raddr) < NBANK) ? len_q[raddr] : '0;

endmodule

`default_nettype wire

// File: rtl/rec_play_ctrl.sv
// ============================================================================
// rec_play_ctrl : record/playback sequencer owning the six-bank note SRAM.
// Optional build macro REC_PLAY_LOOP_EN adds the loop input. Rev 1.0
// ============================================================================
`default_nettype none

module rec_play_ctrl
  import rec_play_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int NBANK  = DEF_NBANK,
  parameter int NOTE_W = DEF_NOTE_W
) (
  input  logic              clk,
  input  logic              rst,
`ifdef REC_PLAY_LOOP_EN
  input  logic              loop,
`endif
  input  logic              rw_mode,
  input  logic [NBANK-1:0]  bank_sel,
  input  logic [NOTE_W-1:0] key_in,
  input  logic              play_start,
  input  logic              tick,
  input  logic [NOTE_W-1:0] rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [NBANK-1:0]  sram_en,
  output logic              sram_rw,
  output logic [NOTE_W-1:0] sram_din,
  output logic [NOTE_W-1:0] note_out,
  output logic              busy,
  output logic              rec_full,
  output logic              done,
  output logic              sel_err
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int IDX_W = (NBANK > 1) ? $clog2(NBANK) : 1;

  state_t            state, state_nx;
  logic [NBANK-1:0]  bank;
  logic [IDX_W-1:0]  bank_idx, sel_idx, len_raddr;
  logic [LEN_W-1:0]  wr_ptr, len_rd;
  logic [ADDR_W-1:0] rd_ptr;
  logic [NOTE_W-1:0] key_prev;
  logic              tick_pend, sel_ok, at_full, wr_fire, tick_eff, last_note;
  logic              len_we, loop_on;

`ifdef REC_PLAY_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign sel_ok    = onehot_valid(32'(bank_sel));
  assign sel_idx   = IDX_W'(onehot_to_idx(32'(bank_sel)));
  assign len_raddr = (state == IDLE) ? sel_idx : bank_idx;
  assign at_full   = (wr_ptr == LEN_W'(DEPTH));
  assign wr_fire   = (state == REC) && rw_mode && (key_in != '0) &&
                     (key_in != key_prev) && !at_full;
  assign tick_eff  = tick | tick_pend;
  assign last_note = ({1'b0, rd_ptr} == (len_rd - LEN_W'(1)));

  assign busy     = (state != IDLE);
  assign rec_full = (state == REC) && at_full;

  bank_len_file #(
    .NBANK (NBANK),
    .LEN_W (LEN_W),
    .IDX_W (IDX_W)
  ) u_len (
    .clk   (clk),
    .rst   (rst),
    .we    (len_we),
    .waddr (bank_idx),
    .wdata (wr_ptr),
    .raddr (len_raddr),
    .rdata (len_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    sram_en   = '0;
    sram_rw   = 1'b0;
    sram_addr = '0;
    sram_din  = '0;
    len_we    = 1'b0;
    case (state)
      IDLE: begin
        if (rw_mode) begin
          if (sel_ok) state_nx = REC;
        end else if (play_start && sel_ok && (len_rd != '0)) begin
          state_nx = PLAY_FETCH;
        end
      end
      REC: begin
        if (!rw_mode) begin
          state_nx = IDLE;
          len_we   = 1'b1;
        end else if (wr_fire) begin
          sram_en   = bank;
          sram_rw   = 1'b1;
          sram_addr = wr_ptr[ADDR_W-1:0];
          sram_din  = key_in;
        end
      end
      PLAY_FETCH: begin
        if (rw_mode) begin
          state_nx = IDLE;
        end else begin
          sram_en   = bank;
          sram_addr = rd_ptr;
          state_nx  = PLAY_WAIT;
        end
      end
      PLAY_WAIT: state_nx = rw_mode ? IDLE : PLAY_HOLD;
      PLAY_HOLD: begin
        if (rw_mode) begin
          state_nx = IDLE;
        end else if (tick_eff) begin
          if (last_note) state_nx = loop_on ? PLAY_FETCH : IDLE;
          else           state_nx = PLAY_FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank      <= '0;
      bank_idx  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      key_prev  <= '0;
      tick_pend <= 1'b0;
      note_out  <= '0;
      done      <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      key_prev <= key_in;
      case (state)
        IDLE: begin
          tick_pend <= 1'b0;
          if (rw_mode || play_start) begin
            if (sel_ok) begin
              bank     <= bank_sel;
              bank_idx <= sel_idx;
              sel_err  <= 1'b0;
              if (rw_mode) begin
                wr_ptr <= '0;
              end else begin
                rd_ptr <= '0;
                if (len_rd == '0) done <= 1'b1;
              end
            end else begin
              sel_err <= 1'b1;
            end
          end
        end
        REC: if (wr_fire) wr_ptr <= wr_ptr + LEN_W'(1);
        PLAY_FETCH, PLAY_WAIT: begin
          // Ticks seen before the note is on screen are kept for HOLD.
          if (rw_mode) begin
            note_out <= '0;
          end else begin
            if (tick) tick_pend <= 1'b1;
            if (state == PLAY_WAIT) note_out <= rd_data;
          end
        end
        PLAY_HOLD: begin
          if (rw_mode) begin
            note_out <= '0;
          end else if (tick_eff) begin
            tick_pend <= 1'b0;
            if (last_note) begin
              done <= 1'b1;
              if (loop_on) rd_ptr <= '0;
              else         note_out <= '0;
            end else begin
              rd_ptr <= rd_ptr + ADDR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rec_play_ctrl.sv
// Scoreboard bench for rec_play_ctrl: stimulus pushes expected SRAM/note/done
// events; a negedge monitor pops and compares every event the DUT presents.
`default_nettype none

module tb_rec_play_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;
  localparam int NBANK  = 6;
  localparam int NOTE_W = 8;

  localparam logic [1:0] K_WR = 2'd0, K_RD = 2'd1, K_NOTE = 2'd2, K_DONE = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [5:0] en;
    logic [7:0] addr;
    logic [7:0] data;
  } ev_t;

  logic              clk = 1'b0, rst = 1'b1;
  logic              rw_mode = 1'b0, play_start = 1'b0, tick = 1'b0;
  logic [NBANK-1:0]  bank_sel = '0;
  logic [NOTE_W-1:0] key_in = '0;
  logic [NOTE_W-1:0] rd_data;
  logic [ADDR_W-1:0] sram_addr;
  logic [NBANK-1:0]  sram_en;
  logic              sram_rw, busy, rec_full, done, sel_err;
  logic [NOTE_W-1:0] sram_din, note_out;
`ifdef REC_PLAY_LOOP_EN
  logic              loop = 1'b0;
`endif

  rec_play_ctrl #(
    .ADDR_W (ADDR_W), .DEPTH (DEPTH), .NBANK (NBANK), .NOTE_W (NOTE_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef REC_PLAY_LOOP_EN
    .loop       (loop),
`endif
    .rw_mode    (rw_mode),
    .bank_sel   (bank_sel),
    .key_in     (key_in),
    .play_start (play_start),
    .tick       (tick),
    .rd_data    (rd_data),
    .sram_addr  (sram_addr),
    .sram_en    (sram_en),
    .sram_rw    (sram_rw),
    .sram_din   (sram_din),
    .note_out   (note_out),
    .busy       (busy),
    .rec_full   (rec_full),
    .done       (done),
    .sel_err    (sel_err)
  );

  always #5 clk = ~clk;

  // Six-bank SRAM with registered, OR-combined read data.
  logic [7:0] mem [6][256];

  function automatic logic [7:0] sram_read();
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 6; b++)
      if (sram_en[b] && !sram_rw) r = r | mem[b][sram_addr];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 6; b++)
      if (sram_en[b] && sram_rw) mem[b][sram_addr] <= sram_din;
    rd_data <= sram_read();
  end

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_rd_cyc = -100;
  logic [7:0] prev_note = '0;

  function automatic ev_t mk(logic [1:0] k, logic [5:0] e, logic [7:0] a, logic [7:0] d);
    ev_t v;
    v.kind = k; v.en = e; v.addr = a; v.data = d;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic got(ev_t a);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind=%0d en=%b addr=%0d data=%h, expected none (t=%0t)",
               a.kind, a.en, a.addr, a.data, $time);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL event: got kind=%0d en=%b addr=%0d data=%h, expected kind=%0d en=%b addr=%0d data=%h (t=%0t)",
                 a.kind, a.en, a.addr, a.data, e.kind, e.en, e.addr, e.data, $time);
      end
    end
  endtask

  // Monitor: ordering within a cycle is SRAM access, then done, then note change.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (sram_en != '0) begin
          got(mk(sram_rw ? K_WR : K_RD, sram_en, sram_addr, sram_rw ? sram_din : 8'h00));
          if (!sram_rw) last_rd_cyc = cyc;
        end
        if (done) got(mk(K_DONE, 6'd0, 8'd0, 8'd0));
        if (note_out != prev_note) begin
          got(mk(K_NOTE, 6'd0, 8'd0, note_out));
          if (note_out != '0) chk("read_to_note_latency", cyc - last_rd_cyc, 2);
        end
      end
      prev_note = note_out;
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(string name, int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) step(1);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_ticks(int ncyc, int period);
    for (int i = 1; i <= ncyc; i++) begin
      tick = (i % period == 0);
      step(1);
    end
    tick = 1'b0;
  endtask

  task automatic press(logic [7:0] k);
    key_in = k;
    step(1);
  endtask

  initial begin
    // Reset state
    step(3);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_rw", sram_rw, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_note_out", note_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sel_err", sel_err, 0);
    rst = 1'b0;
    step(2);

    // Record three keys into bank 0
    exp_q.push_back(mk(K_WR, 6'b000001, 8'd0, 8'h01));
    exp_q.push_back(mk(K_WR, 6'b000001, 8'd1, 8'h04));
    exp_q.push_back(mk(K_WR, 6'b000001, 8'd2, 8'h10));
    bank_sel = 6'b000001; rw_mode = 1'b1;
    step(1);
    chk("rec_busy", busy, 1);
    press(8'h01); press(8'h00); press(8'h04); press(8'h04); press(8'h04);
    press(8'h10); press(8'h00);
    chk("rec_not_full", rec_full, 0);
    rw_mode = 1'b0;
    step(1);
    chk("rec_end_busy", busy, 0);
    wait_drain("rec_writes", 5);

    // Play bank 0 back at one tick per 20 cycles
    exp_q.push_back(mk(K_RD, 6'b000001, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h01));
    exp_q.push_back(mk(K_RD, 6'b000001, 8'd1, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h04));
    exp_q.push_back(mk(K_RD, 6'b000001, 8'd2, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h10));
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h00));
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    chk("play_busy", busy, 1);
    run_ticks(70, 20);
    chk("play_end_busy", busy, 0);
    chk("play_end_note", note_out, 0);
    wait_drain("play_events", 5);

    // Fill bank 2 (DEPTH=4) with six distinct keys
    exp_q.push_back(mk(K_WR, 6'b000100, 8'd0, 8'h01));
    exp_q.push_back(mk(K_WR, 6'b000100, 8'd1, 8'h02));
    exp_q.push_back(mk(K_WR, 6'b000100, 8'd2, 8'h04));
    exp_q.push_back(mk(K_WR, 6'b000100, 8'd3, 8'h08));
    bank_sel = 6'b000100; rw_mode = 1'b1;
    step(1);
    press(8'h01); press(8'h02); press(8'h04);
    chk("full_before_4th", rec_full, 0);
    press(8'h08);
    chk("full_after_4th", rec_full, 1);
    press(8'h10); press(8'h20); press(8'h00);
    chk("full_held", rec_full, 1);
    rw_mode = 1'b0;
    step(1);
    chk("full_cleared_idle", rec_full, 0);
    wait_drain("full_writes", 3);

    // Empty bank: immediate done, never busy
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    bank_sel = 6'b000010; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    chk("empty_busy", busy, 0);
    step(1);
    chk("empty_busy2", busy, 0);
    wait_drain("empty_done", 3);

    // Multi-hot select at play and record starts
    bank_sel = 6'b000011; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    chk("inv_play_sel_err", sel_err, 1);
    chk("inv_play_busy", busy, 0);
    rw_mode = 1'b1;
    step(2);
    chk("inv_rec_busy", busy, 0);
    chk("inv_rec_sel_err", sel_err, 1);
    rw_mode = 1'b0; bank_sel = '0;
    step(3);
    wait_drain("inv_quiet", 1);

    // Valid start clears sel_err; abort from PLAY_HOLD via rw_mode
    exp_q.push_back(mk(K_RD, 6'b000001, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h01));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h00));
    bank_sel = 6'b000001; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    chk("valid_clears_sel_err", sel_err, 0);
    step(6);
    chk("hold_busy", busy, 1);
    chk("hold_note", note_out, 8'h01);
    bank_sel = '0; rw_mode = 1'b1;
    step(1);
    chk("abort_busy", busy, 0);
    chk("abort_note", note_out, 0);
    step(3);
    chk("abort_then_inv_sel", sel_err, 1);
    rw_mode = 1'b0;
    step(2);
    wait_drain("abort_events", 2);

    // Reset in the middle of recording
    exp_q.push_back(mk(K_WR, 6'b000001, 8'd0, 8'h20));
    bank_sel = 6'b000001; rw_mode = 1'b1;
    step(1);
    press(8'h20);
    key_in = 8'h02; rst = 1'b1;
    #1;
    chk("rrst_sram_en", sram_en, 0);
    chk("rrst_sram_din", sram_din, 0);
    chk("rrst_busy", busy, 0);
    chk("rrst_rec_full", rec_full, 0);
    step(2);
    rst = 1'b0; rw_mode = 1'b0; key_in = '0;
    step(1);
    wait_drain("rrst_write", 1);
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    bank_sel = 6'b000100; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    step(2);
    wait_drain("len2_cleared", 2);
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    bank_sel = 6'b000001; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    step(2);
    wait_drain("len0_cleared", 2);

`ifdef REC_PLAY_LOOP_EN
    // Two-note bank played in a loop, then released on the second pass
    exp_q.push_back(mk(K_WR, 6'b001000, 8'd0, 8'h40));
    exp_q.push_back(mk(K_WR, 6'b001000, 8'd1, 8'h80));
    bank_sel = 6'b001000; rw_mode = 1'b1;
    step(1);
    press(8'h40); press(8'h80); press(8'h00);
    rw_mode = 1'b0;
    step(1);
    wait_drain("loop_rec", 3);
    exp_q.push_back(mk(K_RD, 6'b001000, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h40));
    exp_q.push_back(mk(K_RD, 6'b001000, 8'd1, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h80));
    exp_q.push_back(mk(K_RD, 6'b001000, 8'd0, 8'h00));
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h40));
    exp_q.push_back(mk(K_RD, 6'b001000, 8'd1, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h80));
    exp_q.push_back(mk(K_DONE, 6'd0, 8'd0, 8'h00));
    exp_q.push_back(mk(K_NOTE, 6'd0, 8'd0, 8'h00));
    loop = 1'b1; play_start = 1'b1;
    step(1);
    play_start = 1'b0;
    for (int i = 1; i <= 55; i++) begin
      if (i == 35) loop = 1'b0;
      tick = (i % 10 == 0);
      step(1);
    end
    tick = 1'b0;
    chk("loop_end_busy", busy, 0);
    wait_drain("loop_events", 5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
